// File: rtl/fp_accum_seq_if.sv
// Operand stream into the accumulator: one word per element, valid/ready handshake.
// Latency: none, pure wiring.
// Backpressure: the producer holds in_data/in_valid until in_ready is seen high.
interface fp_accum_seq_if #(
   parameter int W = 32
);
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/fp_accum_seq.sv
// Sequential FP accumulator: sums a count-framed run of operands into init_val (add or subtract).
// Latency: 4 cycles per element after acceptance; sum_valid at start+1+4N back-to-back.
// Backpressure: in_ready is high only while waiting for the next element; in_valid low stalls forever.
module fp_accum_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int CNT_W = 8,
   localparam int W    = 1 + EXP_W + MAN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic             mode,
   input  logic [W-1:0]     init_val,
   fp_accum_seq_if.slave    in_if,
   output logic [W-1:0]     sum_out,
   output logic             sum_valid,
   output logic             busy,
   output logic             overflow
);

   localparam int F       = MAN_W + 1;          // fraction width including hidden bit
   localparam int LZ_W    = $clog2(F + 1);
   localparam int EXP_INF = (1 << EXP_W) - 1;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WAIT_IN = 3'd1;
   localparam logic [2:0] S_ALIGN   = 3'd2;
   localparam logic [2:0] S_ADDSUB  = 3'd3;
   localparam logic [2:0] S_NORM    = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   logic [2:0]       state;
   logic [W-1:0]     acc;
   logic [CNT_W-1:0] remaining;
   logic             mode_q;
   logic             overflow_q;
   logic [W-1:0]     op_q;          // operand with sign already inverted for subtract mode

   // aligned operands (ALIGN -> ADDSUB)
   logic             a_sign, b_sign;
   logic [F-1:0]     a_frac, b_frac;
   logic [EXP_W-1:0] big_exp;

   // raw signed-magnitude result (ADDSUB -> NORM)
   logic [F:0]       res_mag;
   logic             res_sign;
   logic [EXP_W-1:0] res_exp;

   // field views
   logic             op_sign, acc_sign;
   logic [EXP_W-1:0] op_exp, acc_exp;
   logic [F-1:0]     op_frac, acc_frac;
   logic             op_is_zero, op_is_inf;

   assign op_sign    = op_q[W-1];
   assign op_exp     = op_q[W-2:MAN_W];
   assign acc_sign   = acc[W-1];
   assign acc_exp    = acc[W-2:MAN_W];
   // exponent zero means zero; denormal fractions are flushed
   assign op_frac    = (op_exp  == '0) ? '0 : {1'b1, op_q[MAN_W-1:0]};
   assign acc_frac   = (acc_exp == '0) ? '0 : {1'b1, acc[MAN_W-1:0]};
   assign op_is_zero = (op_exp == '0);
   assign op_is_inf  = (op_exp == EXP_ONES);

   // ALIGN: pick the larger-exponent operand and truncate-shift the other onto its grid
   logic             al_a_sign, al_b_sign;
   logic [F-1:0]     al_a_frac, al_b_src, al_b_frac;
   logic [EXP_W-1:0] al_exp, exp_diff;
   always_comb begin
      if (acc_exp >= op_exp) begin
         exp_diff  = acc_exp - op_exp;
         al_exp    = acc_exp;
         al_a_sign = acc_sign;
         al_a_frac = acc_frac;
         al_b_sign = op_sign;
         al_b_src  = op_frac;
      end else begin
         exp_diff  = op_exp - acc_exp;
         al_exp    = op_exp;
         al_a_sign = op_sign;
         al_a_frac = op_frac;
         al_b_sign = acc_sign;
         al_b_src  = acc_frac;
      end
      al_b_frac = (int'(exp_diff) > MAN_W) ? '0 : (al_b_src >> exp_diff);
   end

   // ADDSUB: magnitude add on equal signs, larger-minus-smaller otherwise
   logic [F:0] as_mag;
   logic       as_sign;
   always_comb begin
      if (a_sign == b_sign) begin
         as_mag  = {1'b0, a_frac} + {1'b0, b_frac};
         as_sign = a_sign;
      end else if (a_frac >= b_frac) begin
         as_mag  = {1'b0, a_frac - b_frac};
         as_sign = a_sign;
      end else begin
         as_mag  = {1'b0, b_frac - a_frac};
         as_sign = b_sign;
      end
   end

   // NORM: leading-zero count over the fraction field (highest set bit wins)
   logic [LZ_W-1:0] lzc;
   always_comb begin
      lzc = LZ_W'(F);
      for (int i = 0; i < F; i++) begin
         if (res_mag[i]) lzc = LZ_W'(F - 1 - i);
      end
   end

   // NORM: renormalise, flush underflow to +0, saturate overflow to signed infinity
   logic [F-1:0]     norm_shift;
   logic [MAN_W-1:0] nrm_man;
   int               nrm_exp;
   logic             nrm_zero, nrm_inf;
   logic [W-1:0]     nrm_val;
   always_comb begin
      norm_shift = res_mag[F-1:0] << lzc;
      nrm_man    = norm_shift[MAN_W-1:0];
      nrm_exp    = int'(res_exp) - int'(lzc);
      if (res_mag[F]) begin
         nrm_man = res_mag[F-1:1];
         nrm_exp = int'(res_exp) + 1;
      end
      nrm_zero = (res_mag == '0) || (nrm_exp <= 0);
      nrm_inf  = !nrm_zero && (nrm_exp >= EXP_INF);
      if (nrm_zero)
         nrm_val = '0;
      else if (nrm_inf)
         nrm_val = {res_sign, EXP_ONES, {MAN_W{1'b0}}};
      else
         nrm_val = {res_sign, nrm_exp[EXP_W-1:0], nrm_man};
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         acc        <= '0;
         remaining  <= '0;
         mode_q     <= 1'b0;
         overflow_q <= 1'b0;
         op_q       <= '0;
         a_sign     <= 1'b0;
         b_sign     <= 1'b0;
         a_frac     <= '0;
         b_frac     <= '0;
         big_exp    <= '0;
         res_mag    <= '0;
         res_sign   <= 1'b0;
         res_exp    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  acc        <= init_val;
                  remaining  <= count;
                  mode_q     <= mode;
                  overflow_q <= 1'b0;
                  state      <= (count == '0) ? S_DONE : S_WAIT_IN;
               end
            end
            S_WAIT_IN: begin
               if (in_if.in_valid) begin
                  op_q  <= {in_if.in_data[W-1] ^ mode_q, in_if.in_data[W-2:0]};
                  state <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               a_sign  <= al_a_sign;
               b_sign  <= al_b_sign;
               a_frac  <= al_a_frac;
               b_frac  <= al_b_frac;
               big_exp <= al_exp;
               state   <= S_ADDSUB;
            end
            S_ADDSUB: begin
               res_mag  <= as_mag;
               res_sign <= as_sign;
               res_exp  <= big_exp;
               state    <= S_NORM;
            end
            S_NORM: begin
               // zero operands and post-overflow operands still consume an element slot
               if (!overflow_q && !op_is_zero) begin
                  if (op_is_inf) begin
                     acc        <= {op_sign, EXP_ONES, {MAN_W{1'b0}}};
                     overflow_q <= 1'b1;
                  end else begin
                     acc <= nrm_val;
                     if (nrm_inf) overflow_q <= 1'b1;
                  end
               end
               remaining <= remaining - CNT_W'(1);
               state     <= (remaining == CNT_W'(1)) ? S_DONE : S_WAIT_IN;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_if.in_ready = (state == S_WAIT_IN);
   assign sum_out        = acc;
   assign sum_valid      = (state == S_DONE);
   assign busy           = (state != S_IDLE);
   assign overflow       = overflow_q;

endmodule
